// File: rtl/dll_code_ctrl.sv
// Lock controller for the coarse/fine delay line: bang-bang PD in, thermometer T/Tb and fine Q out.
// Latency: one clk_ref edge from a PD sample to new codes; next sample no sooner than SETTLE edges later.
// Backpressure: none; PD is only looked at when the settle counter is 0, otherwise ignored.
module dll_code_ctrl #(
    parameter int SETTLE     = 4,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_RUN = 16,
    parameter int Q_INIT     = 32,
    parameter int N_INIT     = 0
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic        en,
    input  logic        pd_up,
    input  logic        pd_dn,
    output logic [15:0] T,
    output logic [15:0] Tb,
    output logic [9:0]  Q,
    output logic        coarse_done,
    output logic        locked,
    output logic        sat_err
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_RUN + 1);

    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);
    localparam logic [RW-1:0] REV_LAST  = RW'(LOCK_CNT - 1);
    localparam logic [UW-1:0] RUN_LAST  = UW'(UNLOCK_RUN - 1);
    localparam logic [4:0]    N_RST     = 5'(N_INIT);
    localparam logic [5:0]    Q_RST     = 6'(Q_INIT);

    typedef enum logic [1:0] {
        IDLE,
        COARSE,
        FINE,
        LOCK
    } state_t;

    function automatic logic [15:0] therm(input logic [4:0] stages);
        logic [16:0] v;
        v = (17'd1 << stages) - 17'd1;
        return v[15:0];
    endfunction

    state_t          state, state_nxt;
    logic [4:0]      n_q, n_nxt;
    logic [5:0]      q_q, q_nxt;
    logic [SW-1:0]   settle_q, settle_nxt;
    logic [RW-1:0]   rev_q, rev_nxt;
    logic [UW-1:0]   run_q, run_nxt;
    logic            dir_q, dir_nxt;
    logic            dir_vld_q, dir_vld_nxt;
    logic            cd_nxt, lk_nxt, se_nxt;

    logic            up, dn, samp, reversal;
    logic [4:0]      fs_n;
    logic [5:0]      fs_q;
    logic            fs_sat;

    assign up       = pd_up & ~pd_dn;
    assign dn       = pd_dn & ~pd_up;
    assign samp     = (state != IDLE) && (settle_q == '0) && (up || dn);
    assign reversal = dir_vld_q && (up != dir_q);

    // Fine step with carry into / borrow from the coarse line at the Q range ends.
    always_comb begin
        fs_n   = n_q;
        fs_q   = q_q;
        fs_sat = 1'b0;
        if (up) begin
            if (q_q != 6'd63) begin
                fs_q = q_q + 6'd1;
            end else if (n_q != 5'd16) begin
                fs_n = n_q + 5'd1;
                fs_q = 6'd0;
            end else begin
                fs_sat = 1'b1;
            end
        end else if (dn) begin
            if (q_q != 6'd0) begin
                fs_q = q_q - 6'd1;
            end else if (n_q != 5'd0) begin
                fs_n = n_q - 5'd1;
                fs_q = 6'd63;
            end else begin
                fs_sat = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        n_nxt       = n_q;
        q_nxt       = q_q;
        settle_nxt  = (settle_q == '0) ? '0 : settle_q - 1'b1;
        rev_nxt     = rev_q;
        run_nxt     = run_q;
        dir_nxt     = dir_q;
        dir_vld_nxt = dir_vld_q;
        cd_nxt      = coarse_done;
        lk_nxt      = locked;
        se_nxt      = sat_err;

        case (state)
            IDLE: begin
                settle_nxt = SETTLE_LD;
                if (en) begin
                    state_nxt = COARSE;
                end
            end
            COARSE: begin
                if (samp) begin
                    if (up && n_q != 5'd16) begin
                        n_nxt = n_q + 5'd1;
                    end else begin
                        // A dn, or an up with the coarse line exhausted, hands over to fine tracking.
                        se_nxt    = sat_err | up;
                        state_nxt = FINE;
                        cd_nxt    = 1'b1;
                        q_nxt     = Q_RST;
                    end
                end
            end
            FINE: begin
                if (samp) begin
                    n_nxt   = fs_n;
                    q_nxt   = fs_q;
                    se_nxt  = sat_err | fs_sat;
                    rev_nxt = reversal ? rev_q + 1'b1 : '0;
                    if (reversal && rev_q == REV_LAST) begin
                        state_nxt = LOCK;
                        lk_nxt    = 1'b1;
                        rev_nxt   = '0;
                        run_nxt   = '0;
                    end
                end
            end
            LOCK: begin
                if (samp) begin
                    n_nxt   = fs_n;
                    q_nxt   = fs_q;
                    se_nxt  = sat_err | fs_sat;
                    run_nxt = reversal ? '0 : run_q + 1'b1;
                    if (!reversal && run_q == RUN_LAST) begin
                        state_nxt = FINE;
                        lk_nxt    = 1'b0;
                        rev_nxt   = '0;
                        run_nxt   = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (samp) begin
            dir_nxt     = up;
            dir_vld_nxt = 1'b1;
            if (n_nxt != n_q || q_nxt != q_q) begin
                settle_nxt = SETTLE_LD;
            end
        end

        // Dropping en abandons the loop; only the saturation flag survives until rst.
        if (!en) begin
            state_nxt   = IDLE;
            n_nxt       = N_RST;
            q_nxt       = Q_RST;
            settle_nxt  = SETTLE_LD;
            rev_nxt     = '0;
            run_nxt     = '0;
            dir_nxt     = 1'b0;
            dir_vld_nxt = 1'b0;
            cd_nxt      = 1'b0;
            lk_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state       <= IDLE;
            n_q         <= N_RST;
            q_q         <= Q_RST;
            settle_q    <= SETTLE_LD;
            rev_q       <= '0;
            run_q       <= '0;
            dir_q       <= 1'b0;
            dir_vld_q   <= 1'b0;
            coarse_done <= 1'b0;
            locked      <= 1'b0;
            sat_err     <= 1'b0;
            T           <= therm(N_RST);
            Tb          <= ~therm(N_RST);
        end else begin
            state       <= state_nxt;
            n_q         <= n_nxt;
            q_q         <= q_nxt;
            settle_q    <= settle_nxt;
            rev_q       <= rev_nxt;
            run_q       <= run_nxt;
            dir_q       <= dir_nxt;
            dir_vld_q   <= dir_vld_nxt;
            coarse_done <= cd_nxt;
            locked      <= lk_nxt;
            sat_err     <= se_nxt;
            T           <= therm(n_nxt);
            Tb          <= ~therm(n_nxt);
        end
    end

    assign Q = {4'b0000, q_q};

endmodule

// File: tb/tb_dll_code_ctrl.sv
// Scoreboard bench for dll_code_ctrl: stimulus pushes expected output changes, a monitor pops on each change.
module tb_dll_code_ctrl;

    logic        clk_ref = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pd_up = 1'b0;
    logic        pd_dn = 1'b0;
    logic [15:0] T, Tb;
    logic [9:0]  Q;
    logic        coarse_done, locked, sat_err;

    dll_code_ctrl dut (
        .clk_ref     (clk_ref),
        .rst         (rst),
        .en          (en),
        .pd_up       (pd_up),
        .pd_dn       (pd_dn),
        .T           (T),
        .Tb          (Tb),
        .Q           (Q),
        .coarse_done (coarse_done),
        .locked      (locked),
        .sat_err     (sat_err)
    );

    always #5 clk_ref = ~clk_ref;

    typedef struct {
        int          cyc;
        logic [15:0] t;
        logic [9:0]  q;
        logic        cd, lk, se;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   unexp = 0;
    bit   mon_on = 1'b0;
    logic [44:0] prev, cur;

    // Bench model of the controller codes and flags.
    int mn, mq;
    bit mcd, mlk, mse;

    always @(posedge clk_ref) cyc <= cyc + 1;

    function automatic logic [15:0] therm(input int n);
        logic [16:0] v;
        v = (17'd1 << n) - 17'd1;
        return v[15:0];
    endfunction

    always @(negedge clk_ref) begin
        cur = {T, Tb, Q, coarse_done, locked, sat_err};
        if (mon_on && cur !== prev) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                unexp++;
                $display("FAIL unexpected_change at cyc %0d: T=%h Q=%0d cd=%b lk=%b se=%b",
                         cyc, T, Q, coarse_done, locked, sat_err);
            end else begin
                mon_e = sb.pop_front();
                if (T !== mon_e.t || Tb !== ~mon_e.t || Q !== mon_e.q || coarse_done !== mon_e.cd ||
                    locked !== mon_e.lk || sat_err !== mon_e.se || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                    errors++;
                    $display("FAIL %s got T=%h Tb=%h Q=%0d cd=%b lk=%b se=%b cyc=%0d, want T=%h Q=%0d cd=%b lk=%b se=%b cyc=%0d",
                             mon_e.nm, T, Tb, Q, coarse_done, locked, sat_err, cyc,
                             mon_e.t, mon_e.q, mon_e.cd, mon_e.lk, mon_e.se, mon_e.cyc);
                end
            end
        end
        prev = cur;
    end

    task automatic push(input int c, input string nm);
        exp_t e;
        e.cyc = c;
        e.t   = therm(mn);
        e.q   = 10'(mq);
        e.cd  = mcd;
        e.lk  = mlk;
        e.se  = mse;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int budget;
        int k;
        budget = 6 * sb.size() + 20;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk_ref);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d expected changes never seen, wanted 0 pending", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic drive(input bit u, input bit d, input int c, input string nm);
        pd_up = u;
        pd_dn = d;
        push(c, nm);
        wait_drain(nm);
    endtask

    task automatic hold_check(input int ncyc, input string nm);
        int u0;
        u0 = unexp;
        repeat (ncyc) @(negedge clk_ref);
        #1;
        checks++;
        if (T !== therm(mn) || Tb !== ~therm(mn) || Q !== 10'(mq) || coarse_done !== mcd ||
            locked !== mlk || sat_err !== mse || unexp != u0) begin
            errors++;
            $display("FAIL %s got T=%h Tb=%h Q=%0d cd=%b lk=%b se=%b, want T=%h Q=%0d cd=%b lk=%b se=%b, no change",
                     nm, T, Tb, Q, coarse_done, locked, sat_err, therm(mn), mq, mcd, mlk, mse);
        end
    endtask

    task automatic up_step();
        if (mq < 63) mq++;
        else if (mn < 16) begin mn++; mq = 0; end
        else mse = 1'b1;
    endtask

    task automatic dn_step();
        if (mq > 0) mq--;
        else if (mn > 0) begin mn--; mq = 63; end
        else mse = 1'b1;
    endtask

    task automatic idle_model(input bit clr_sat);
        mn = 0; mq = 32; mcd = 1'b0; mlk = 1'b0;
        if (clr_sat) mse = 1'b0;
    endtask

    task automatic coarse_ups(input int cnt, input string nm);
        pd_up = 1'b1;
        pd_dn = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            mn++;
            push(-1, nm);
        end
        wait_drain(nm);
    endtask

    task automatic coarse_dn();
        mcd = 1'b1;
        mq  = 32;
        drive(1'b0, 1'b1, -1, "coarse_dn");
    endtask

    task automatic alternate_to_lock();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) up_step();
            else dn_step();
            if (i == 7) mlk = 1'b1;
            drive(i % 2 == 0, i % 2 == 1, -1, "fine_alt");
        end
    endtask

    initial begin
        int c0;
        idle_model(1'b1);
        en = 1'b1;
        pd_up = 1'b1;
        repeat (3) @(negedge clk_ref);
        hold_check(0, "reset_override");
        en = 1'b0;
        pd_up = 1'b0;
        @(negedge clk_ref);
        rst = 1'b0;
        hold_check(2, "idle_hold");
        mon_on = 1'b1;

        // Coarse search with step timing, then handover on dn at T=0x00FF.
        @(negedge clk_ref);
        #1;
        c0 = cyc;
        en = 1'b1;
        pd_up = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            mn = i;
            push(c0 + 1 + 4 * i, "coarse_step");
        end
        wait_drain("coarse_step");
        mcd = 1'b1;
        mq = 32;
        drive(1'b0, 1'b1, cyc + 4, "coarse_dn_timed");

        alternate_to_lock();
        hold_check(0, "locked_state");
        for (int i = 0; i < 16; i++) begin
            dn_step();
            if (i == 15) mlk = 1'b0;
            drive(1'b0, 1'b1, -1, "lock_run");
        end
        pd_up = 1'b1;
        pd_dn = 1'b1;
        hold_check(12, "pd_both");
        pd_up = 1'b0;
        pd_dn = 1'b0;
        hold_check(8, "pd_none");

        // Drop en from FINE, then again mid-COARSE at T=0x003F.
        idle_model(1'b0);
        en = 1'b0;
        push(cyc + 1, "en_off_fine");
        wait_drain("en_off_fine");
        en = 1'b1;
        coarse_ups(6, "coarse_to_3f");
        idle_model(1'b0);
        en = 1'b0;
        pd_up = 1'b0;
        push(cyc + 1, "en_off_coarse");
        wait_drain("en_off_coarse");

        // Carry from n=3,Q=63 and borrow from n=3,Q=0.
        en = 1'b1;
        coarse_ups(3, "coarse_n3");
        coarse_dn();
        for (int i = 0; i < 31; i++) begin
            up_step();
            drive(1'b1, 1'b0, -1, "fine_up");
        end
        up_step();
        drive(1'b1, 1'b0, -1, "carry");
        for (int i = 0; i < 64; i++) begin
            dn_step();
            drive(1'b0, 1'b1, -1, "fine_dn");
        end
        dn_step();
        drive(1'b0, 1'b1, -1, "borrow");

        // Saturation at n=16,Q=63 after a clean reset.
        idle_model(1'b1);
        rst = 1'b1;
        en = 1'b0;
        pd_dn = 1'b0;
        push(cyc + 1, "rst_fine");
        wait_drain("rst_fine");
        rst = 1'b0;
        en = 1'b1;
        coarse_ups(15, "coarse_n15");
        coarse_dn();
        for (int i = 0; i < 95; i++) begin
            up_step();
            drive(1'b1, 1'b0, -1, "fine_up_top");
        end
        up_step();
        drive(1'b1, 1'b0, -1, "sat_set");
        hold_check(12, "sat_hold");
        pd_dn = 1'b1;
        hold_check(8, "sat_pd_both");
        idle_model(1'b0);
        en = 1'b0;
        pd_up = 1'b0;
        pd_dn = 1'b0;
        push(cyc + 1, "en_off_sat_sticky");
        wait_drain("en_off_sat_sticky");

        // Lock again, then synchronous reset mid-LOCK clears everything.
        en = 1'b1;
        coarse_ups(1, "coarse_n1");
        coarse_dn();
        alternate_to_lock();
        idle_model(1'b1);
        rst = 1'b1;
        pd_up = 1'b0;
        pd_dn = 1'b0;
        push(cyc + 1, "rst_lock");
        wait_drain("rst_lock");
        en = 1'b0;
        @(negedge clk_ref);
        rst = 1'b0;
        hold_check(4, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dll_code_ctrl.md
Name: dll_code_ctrl

Overview:
- Digital lock controller for the coarse/fine delay line (CDL + FDL inside DCDL).
- Samples a bang-bang phase detector and drives the coarse thermometer code T/Tb and the fine code Q.
- Runs a coarse search, then fine tracking, then declares lock. Handles carry and borrow between the fine and coarse codes.
- Sits between the phase detector and DCDL, in the clk_ref domain.

Parameters:
- SETTLE, 4: cycles to wait after any code change before the next PD sample (minimum 1).
- LOCK_CNT, 8: consecutive PD direction reversals required to assert locked.
- UNLOCK_RUN, 16: consecutive same-direction samples in LOCK that drop locked.
- Q_INIT, 32: fine code loaded on entry to FINE (0..63).
- N_INIT, 0: coarse stage count loaded at reset/IDLE (0..16).

Ports:
- clk_ref, input, 1: controller clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: loop enable.
- pd_up, input, 1: delay too short; request more delay.
- pd_dn, input, 1: delay too long; request less delay.
- T, output, 16: coarse thermometer code, T = (1<<n)-1, where n is stage count 0..16.
- Tb, output, 16: always the bitwise inverse of T, registered in the same cycle.
- Q, output, 10: fine code; Q[5:0] is the active code, Q[9:6] is constant 0.
- coarse_done, output, 1: coarse search finished.
- locked, output, 1: loop locked.
- sat_err, output, 1: sticky; a request hit the delay range limit.

Behaviour:
- Reset (rst=1 at edge) values:
  - state=IDLE, n=N_INIT, T=(1<<N_INIT)-1, Tb=~T, Q=Q_INIT.
  - coarse_done=0, locked=0, sat_err=0.
  - settle counter = SETTLE-1, reversal counter = 0, run counter = 0.
  - rst overrides every other input in the same cycle.
- Sample point: PD is sampled only in a cycle where the settle counter is 0 and state is not IDLE.
  - Any code change in that cycle reloads the settle counter to SETTLE-1 on the same edge.
  - Otherwise the counter decrements to 0 and holds there.
- PD decode:
  - up = pd_up & ~pd_dn; dn = pd_dn & ~pd_up.
  - Both or neither set: no code change, counters unchanged, settle counter not reloaded.
- States:
  - IDLE: codes held at reset values. en=1 → COARSE next cycle with settle counter = SETTLE-1.
  - COARSE:
    - On up at a sample point, with n<16: n+1.
    - On up with n=16: set sat_err and go to FINE.
    - On dn at a sample point: go to FINE; n is unchanged; coarse_done=1; Q=Q_INIT.
    - T is not decremented in COARSE.
  - FINE / LOCK step, at a sample point:
    - up: Q<63 → Q+1. Q=63 and n<16 → n+1 and Q=0 (carry). Q=63 and n=16 → hold, sat_err=1.
    - dn: Q>0 → Q-1. Q=0 and n>0 → n-1 and Q=63 (borrow). Q=0 and n=0 → hold, sat_err=1.
  - FINE: the reversal counter increments when the current direction differs from the last valid direction, else clears to 0. Reaching LOCK_CNT → LOCK, locked=1 on the same edge.
  - LOCK:
    - Tracking continues using the FINE step rules.
    - The run counter counts consecutive same-direction samples and clears on a reversal.
    - Reaching UNLOCK_RUN → FINE: locked=0, reversal counter cleared.
- en=0 in any state → IDLE next edge: all outputs and counters return to reset values except sat_err (sticky until rst).
- Latency: PD sample edge → new T/Tb/Q visible after that edge (1 cycle). Next sample no earlier than SETTLE cycles later.
- T and Tb change together on the same edge and are never momentarily non-complementary.

Test Plan:
- rst=1, then en=1 with pd_up held, SETTLE=4:
  - T steps 0x0000→0x0001→0x0003, one step every 4 cycles.
  - On pd_dn at T=0x00FF: coarse_done=1, Q=32, T stays 0x00FF.
- In FINE with LOCK_CNT=8, alternate pd_up/pd_dn at each sample point → locked=1 on the 8th reversal; Q oscillates 32/33.
- Carry: FINE with n=3, Q=63, pd_up → T=0x000F, Q=0. Borrow: n=3, Q=0, pd_dn → T=0x0003, Q=63.
- Saturation:
  - n=16, Q=63, pd_up → codes hold, sat_err=1 and stays 1 until rst.
  - pd_up=pd_dn=1 → no change.
- LOCK then 16 consecutive pd_dn samples → locked=0 at the 16th sample, state FINE, Q decremented 16 times total.
- en=0 mid-COARSE at T=0x003F → next cycle T=0x0000, Tb=0xFFFF, Q=32, coarse_done=0; sync rst mid-LOCK behaves the same and also clears sat_err.
